pc_fetch: RTL

Instruction fetch stage between the program-counter stage and decode. Accepts the next fetch address from the PC stage and issues it to instruction memory. Tracks in-flight requests and buffers returned instructions, tagged with their PC, in a small in-order queue. Presents them to decode with a valid/ready handshake, and discards stale fetches on a redirect flush.

---
 rtl/pc_fetch_if.sv | 30 +++
 rtl/pc_fetch.sv | 93 +++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Handshake bundle between the PC stage, instruction memory and decode.
// The fetch stage uses the master modport; the surrounding environment uses the slave modport.
interface pc_fetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        input  pc_addr, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output pc_ready, imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output pc_addr, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  pc_ready, imem_req, imem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: issues PC addresses to memory, tracks outstanding requests and
// buffers returned instructions with their PC in an in-order queue for decode.
module pc_fetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input logic       clk,
    input logic       rst_n,
    pc_fetch_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [ADDR_W-1:0] afifo  [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [DATA_W-1:0] q_inst [DEPTH];
    logic [PTR_W-1:0]  a_wr, a_rd, q_wr, q_rd;
    logic [CNT_W-1:0]  out_cnt, q_cnt, drop_cnt;

    logic             pop, credit, req, issue, resp_drop, resp_keep;
    logic [SUM_W-1:0] used, flush_sum;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts a same-cycle pop so the slot freed by decode can be refilled at once.
    always_comb begin
        pop       = (q_cnt != '0) & bus.inst_ready;
        used      = SUM_W'(out_cnt) + SUM_W'(q_cnt) + SUM_W'(drop_cnt) - SUM_W'(pop);
        credit    = used < SUM_W'(DEPTH);
        req       = rst_n & bus.pc_valid & credit & ~bus.flush;
        issue     = req & bus.imem_gnt;
        resp_drop = bus.imem_rvalid & ~bus.flush & (drop_cnt != '0);
        resp_keep = bus.imem_rvalid & ~bus.flush & (drop_cnt == '0) & (out_cnt != '0);
        flush_sum = SUM_W'(drop_cnt) + SUM_W'(out_cnt)
                  - SUM_W'(bus.imem_rvalid & ((drop_cnt != '0) | (out_cnt != '0)));
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = bus.pc_addr;
    assign bus.pc_ready   = issue;
    assign bus.inst_valid = (q_cnt != '0);
    assign bus.inst       = q_inst[q_rd];
    assign bus.inst_pc    = q_pc[q_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wr     <= '0;
            a_rd     <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            out_cnt  <= '0;
            q_cnt    <= '0;
            drop_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                afifo[i]  <= '0;
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else if (bus.flush) begin
            // Everything in flight becomes a pending discard; a response this cycle retires one.
            a_wr     <= '0;
            a_rd     <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_cnt    <= '0;
            out_cnt  <= '0;
            drop_cnt <= CNT_W'(flush_sum);
        end else begin
            if (issue) begin
                afifo[a_wr] <= bus.pc_addr;
                a_wr        <= inc(a_wr);
            end
            if (resp_keep) begin
                q_pc[q_wr]   <= afifo[a_rd];
                q_inst[q_wr] <= bus.imem_rdata;
                q_wr         <= inc(q_wr);
                a_rd         <= inc(a_rd);
            end
            if (pop) begin
                q_rd <= inc(q_rd);
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            out_cnt <= out_cnt + CNT_W'(issue) - CNT_W'(resp_keep);
            q_cnt   <= q_cnt + CNT_W'(resp_keep) - CNT_W'(pop);
        end
    end
endmodule
